// File: rtl/soc_confreg_bridge.sv
// Data-port bridge: routes core accesses to the data SRAM or to a small confreg
// block (LED, switches, timer, UART TX FIFO) while keeping one-cycle read timing.
module soc_confreg_bridge #(
  parameter logic [31:0] CONF_BASE  = 32'hBFAF_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_data_en,
  input  logic [3:0]  cpu_data_wen,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  output logic [7:0]  uart_tx_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Word offsets (addr[15:2]) of the register map.
  localparam logic [13:0] OFF_LED   = 14'h3C00;
  localparam logic [13:0] OFF_SW    = 14'h3C01;
  localparam logic [13:0] OFF_TIMER = 14'h3C02;
  localparam logic [13:0] OFF_UDATA = 14'h3C03;
  localparam logic [13:0] OFF_USTAT = 14'h3C04;

  logic        hit, conf_rd, conf_wr, full_word;
  logic [13:0] off;

  assign hit       = cpu_data_en & (cpu_data_addr[31:16] == CONF_BASE[31:16]);
  assign conf_rd   = hit & (cpu_data_wen == 4'h0);
  assign conf_wr   = hit & (cpu_data_wen != 4'h0);
  assign full_word = (cpu_data_wen == 4'hF);
  assign off       = cpu_data_addr[15:2];

  assign data_sram_en    = cpu_data_en & ~hit;
  assign data_sram_wen   = hit ? 4'h0 : cpu_data_wen;
  assign data_sram_addr  = cpu_data_addr;
  assign data_sram_wdata = cpu_data_wdata;

  logic             hit_r_q, hit_r_d;
  logic [31:0]      conf_rdata_q, conf_rdata_d;
  logic [15:0]      led_q, led_d;
  logic [15:0]      sw_meta_q, sw_sync_q;
  logic [31:0]      timer_q, timer_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic        full, empty, pop, push_req, push, ovf_clr;
  logic [31:0] stat, rd_mux;

  // UART TX handshake: a byte leaves the FIFO on every rising edge where
  // uart_tx_valid and uart_tx_ready are both high; valid never drops without a pop.
  assign full          = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty         = (count_q == '0);
  assign pop           = ~empty & uart_tx_ready;
  assign push_req      = conf_wr & (off == OFF_UDATA) & cpu_data_wen[0];
  assign push          = push_req & (~full | pop);
  assign ovf_clr       = conf_wr & (off == OFF_USTAT) & cpu_data_wen[0] & cpu_data_wdata[2];
  assign uart_tx_valid = ~empty;
  assign uart_tx_data  = mem_q[rd_ptr_q];
  assign led_out       = led_q;

  always_comb begin
    stat              = '0;
    stat[0]           = full;
    stat[1]           = empty;
    stat[2]           = ovf_q;
    stat[3+CNT_W:4]   = count_q;
    rd_mux            = '0;
    case (off)
      OFF_LED:   rd_mux = {16'h0000, led_q};
      OFF_SW:    rd_mux = {16'h0000, sw_sync_q};
      OFF_TIMER: rd_mux = timer_q;
      OFF_USTAT: rd_mux = stat;
      default:   rd_mux = '0;
    endcase
  end

  always_comb begin
    hit_r_d      = conf_rd;
    conf_rdata_d = conf_rd ? rd_mux : conf_rdata_q;
    led_d        = (conf_wr & full_word & (off == OFF_LED)) ? cpu_data_wdata[15:0] : led_q;
    // A same-cycle write replaces the increment rather than adding to it.
    timer_d      = (conf_wr & full_word & (off == OFF_TIMER)) ? cpu_data_wdata : timer_q + 32'd1;
    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d      = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (push_req & full & ~pop) ovf_d = 1'b1;
    else if (ovf_clr)           ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_r_q      <= 1'b0;
      conf_rdata_q <= '0;
      led_q        <= '0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      timer_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
    end else begin
      hit_r_q      <= hit_r_d;
      conf_rdata_q <= conf_rdata_d;
      led_q        <= led_d;
      sw_meta_q    <= switch_in;
      sw_sync_q    <= sw_meta_q;
      timer_q      <= timer_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cpu_data_wdata[7:0];
  end

  assign cpu_data_rdata = hit_r_q ? conf_rdata_q : data_sram_rdata;

endmodule
